// File: rtl/be_pkg.sv
// be_pkg: back-end shared types for the sequential ALU.
// Holds the instruction mnemonic enum, the XLEN-independent ALU FSM state
// type and the list of M-extension mnemonics (is_m_op).
// The M extension is enabled by defining RV32I_M_EXT_EN.
package be_pkg;
  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU, SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    FENCE, ECALL, EBREAK,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
    UNKNOWN = 6'h3f
  } RV32I_INSTRUCTION_MNEMONIC_t;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} alu_state_t;

  function automatic logic is_m_op(input RV32I_INSTRUCTION_MNEMONIC_t m);
    return m inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: iterative XLEN-cycle multiply (radix-2 shift-add) and
// restoring divide on operand magnitudes, with a final sign fix.
// Ports: clk, rst_n (async active-low); i_start captures i_op/i_a/i_b;
// o_done is high in the last iteration cycle, when o_result is valid.
// Only instantiated when RV32I_M_EXT_EN is defined.
module iter_muldiv import be_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  RV32I_INSTRUCTION_MNEMONIC_t i_op,
  input  logic [XLEN-1:0]             i_a,
  input  logic [XLEN-1:0]             i_b,
  output logic                        o_done,
  output logic [XLEN-1:0]             o_result
);
  RV32I_INSTRUCTION_MNEMONIC_t r_op;
  logic                 r_run, r_neg, r_sa, r_bz;
  logic [SHAMT_W-1:0]   r_cnt;
  logic [XLEN-1:0]      r_hi, r_lo, r_b;
  logic                 w_sa, w_sb, w_mul, w_ge;
  logic [XLEN:0]        w_sum, w_sh, w_diff;
  logic [XLEN-1:0]      w_nhi, w_nlo, w_q, w_r;
  logic [2*XLEN-1:0]    w_prod;

  assign w_sa  = i_a[XLEN-1] && (i_op inside {MULH, MULHSU, DIV, REM});
  assign w_sb  = i_b[XLEN-1] && (i_op inside {MULH, DIV, REM});
  assign w_mul = r_op inside {MUL, MULH, MULHSU, MULHU};
  // multiply: {r_hi,r_lo} is the partial product with the multiplier in r_lo
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  // divide: r_hi is the partial remainder, r_lo shifts dividend out / quotient in
  assign w_sh   = {r_hi, r_lo[XLEN-1]};
  assign w_diff = w_sh - {1'b0, r_b};
  assign w_ge   = !w_diff[XLEN];
  assign w_nhi  = w_mul ? w_sum[XLEN:1] : (w_ge ? w_diff[XLEN-1:0] : w_sh[XLEN-1:0]);
  assign w_nlo  = w_mul ? {w_sum[0], r_lo[XLEN-1:1]} : {r_lo[XLEN-2:0], w_ge};
  // result is taken from the final step's next values, so it is ready in the last cycle
  assign w_prod = r_neg ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
  assign w_q    = r_bz ? '1 : (r_neg ? -w_nlo : w_nlo);
  assign w_r    = r_sa ? -w_nhi : w_nhi;
  assign o_done = r_run && (r_cnt == SHAMT_W'(XLEN-1));
  assign o_result = w_mul ? ((r_op == MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                          : ((r_op inside {DIV, DIVU}) ? w_q : w_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= MUL;
      r_run <= 1'b0;
      r_neg <= 1'b0;
      r_sa  <= 1'b0;
      r_bz  <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (i_start) begin
      r_op  <= i_op;
      r_run <= 1'b1;
      r_neg <= w_sa ^ w_sb;
      r_sa  <= w_sa;
      r_bz  <= (i_b == '0);
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= w_sa ? -i_a : i_a;
      r_b   <= w_sb ? -i_b : i_b;
    end else if (r_run) begin
      r_hi  <= w_nhi;
      r_lo  <= w_nlo;
      r_cnt <= r_cnt + 1'b1;
      r_run <= !o_done;
    end
  end
endmodule

// File: rtl/rv32_seq_alu.sv
// rv32_seq_alu: sequential RV32I ALU with valid/ready handshakes.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with mnemonic,
// a, b (pre-muxed), rs1, rs2, imm (raw); out_valid/out_ready with
// registered out and cond_jump; busy high while iterating (CALC).
// Define RV32I_M_EXT_EN to add iterative multiply/divide (XLEN+1 latency);
// otherwise M mnemonics behave as unknown ops.
module rv32_seq_alu import be_pkg::*; #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
  input  logic [XLEN-1:0]             a,
  input  logic [XLEN-1:0]             b,
  input  logic [XLEN-1:0]             rs1,
  input  logic [XLEN-1:0]             rs2,
  input  logic [XLEN-1:0]             imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out,
  output logic                        cond_jump,
  output logic                        busy
);
  alu_state_t          r_state, w_next, w_launch;
  logic [XLEN-1:0]     r_out, w_sc_out, w_md_res;
  logic                r_cj, w_cj, w_xfer, w_is_m, w_md_done;
  logic                w_eq, w_lt_s, w_lt_u;
  logic [SHAMT_W-1:0]  w_shamt;

  assign w_xfer  = in_valid && in_ready;
  assign w_eq    = rs1 == rs2;
  assign w_lt_s  = $signed(rs1) < $signed(rs2);
  assign w_lt_u  = rs1 < rs2;
  assign w_shamt = b[SHAMT_W-1:0];
  assign w_cj = (mnemonic == BEQ)  ? w_eq    :
                (mnemonic == BNE)  ? !w_eq   :
                (mnemonic == BLT)  ? w_lt_s  :
                (mnemonic == BGE)  ? !w_lt_s :
                (mnemonic == BLTU) ? w_lt_u  :
                (mnemonic == BGEU) ? !w_lt_u : 1'b0;

  always_comb begin
    w_sc_out = '0;
    case (mnemonic)
      ADD, ADDI, LB, LH, LW, LBU, LHU, SB, SH, SW, JAL, JALR: w_sc_out = a + b;
      SUB:         w_sc_out = a - b;
      XOR, XORI:   w_sc_out = a ^ b;
      OR, ORI:     w_sc_out = a | b;
      AND, ANDI:   w_sc_out = a & b;
      SLL, SLLI:   w_sc_out = a << w_shamt;
      SRL, SRLI:   w_sc_out = a >> w_shamt;
      SRA, SRAI:   w_sc_out = XLEN'($signed(a) >>> w_shamt);
      LUI:         w_sc_out = imm << 12;
      AUIPC:       w_sc_out = a + (imm << 12);
      SLT:         w_sc_out = XLEN'(w_lt_s);
      SLTU:        w_sc_out = XLEN'(w_lt_u);
      SLTI:        w_sc_out = XLEN'($signed(rs1) < $signed(imm));
      SLTIU:       w_sc_out = XLEN'(rs1 < imm);
      default:     w_sc_out = '0;
    endcase
  end

`ifdef RV32I_M_EXT_EN
  assign w_is_m = is_m_op(mnemonic);
  iter_muldiv #(.XLEN(XLEN), .SHAMT_W(SHAMT_W)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_xfer && w_is_m),
    .i_op     (mnemonic),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );
`else
  assign w_is_m    = 1'b0;
  assign w_md_done = 1'b0;
  assign w_md_res  = '0;
`endif

  always_comb begin
    w_next    = r_state;
    w_launch  = S_DONE;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (w_is_m) w_launch = S_CALC;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_launch;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_md_done) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? w_launch : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_cj    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_out <= w_sc_out;
        r_cj  <= w_cj;
      end else if (w_md_done) begin
        r_out <= w_md_res;
      end
    end
  end

  assign out       = r_out;
  assign cond_jump = r_cj;
endmodule

// File: tb/tb_rv32_seq_alu.sv
module tb_rv32_seq_alu;
  import be_pkg::*;

  typedef struct {
    RV32I_INSTRUCTION_MNEMONIC_t m;
    logic [31:0] a, b, r1, r2, im, eo;
    logic ec;
    logic ko;
  } vec_t;

  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, cond_jump, busy;
  logic [31:0] a = 0, b = 0, rs1 = 0, rs2 = 0, imm = 0, out;
  RV32I_INSTRUCTION_MNEMONIC_t mnemonic = ADD;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rv32_seq_alu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mnemonic(mnemonic), .a(a), .b(b), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .cond_jump(cond_jump), .busy(busy)
  );

  task automatic run_op(input RV32I_INSTRUCTION_MNEMONIC_t m, input logic [31:0] av, bv, r1, r2, im,
                        output logic [31:0] res, output logic cj, output int lat);
    @(negedge clk);
    mnemonic = m; a = av; b = bv; rs1 = r1; rs2 = r2; imm = im;
    in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0; mnemonic = ADD; a = ~av; b = ~bv; rs1 = ~r1; rs2 = ~r2; imm = ~im;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out; cj = cond_jump;
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, cond_jump, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags got ov/busy/cj/ir=%b want 0001", {out_valid, busy, cond_jump, in_ready});
    end
    checks++;
    if (out !== 32'h0) begin errors++; $display("FAIL reset_out got %h want 0", out); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_single;
    vec_t v[$];
    logic [31:0] res; logic cj; int lat;
    v.push_back('{ADD,    32'hffffffff, 32'h1,        0, 0, 0, 32'h0, 1'b0, 1'b1});
    v.push_back('{SUB,    32'h5,        32'h7,        0, 0, 0, 32'hfffffffe, 1'b0, 1'b1});
    v.push_back('{XOR,    32'hf0f0f0f0, 32'hff00ff00, 0, 0, 0, 32'h0ff00ff0, 1'b0, 1'b1});
    v.push_back('{ORI,    32'h000000f0, 32'h0000000f, 0, 0, 0, 32'h000000ff, 1'b0, 1'b1});
    v.push_back('{AND,    32'hff00ff00, 32'h0ff00ff0, 0, 0, 0, 32'h0f000f00, 1'b0, 1'b1});
    v.push_back('{SLL,    32'h1,        32'h24,       0, 0, 0, 32'h10, 1'b0, 1'b1});
    v.push_back('{SRL,    32'h80000000, 32'h1f,       0, 0, 0, 32'h1, 1'b0, 1'b1});
    v.push_back('{SRA,    32'h80000000, 32'h21,       0, 0, 0, 32'hc0000000, 1'b0, 1'b1});
    v.push_back('{SRAI,   32'h80000000, 32'h4,        0, 0, 0, 32'hf8000000, 1'b0, 1'b1});
    v.push_back('{LUI,    32'h0,        32'h0,        0, 0, 32'h12345, 32'h12345000, 1'b0, 1'b1});
    v.push_back('{AUIPC,  32'h1000,     32'h0,        0, 0, 32'h1, 32'h2000, 1'b0, 1'b1});
    v.push_back('{SLT,    32'h0, 32'h0, 32'hffffffff, 32'h1, 0, 32'h1, 1'b0, 1'b1});
    v.push_back('{SLTU,   32'h0, 32'h0, 32'hffffffff, 32'h1, 0, 32'h0, 1'b0, 1'b1});
    v.push_back('{SLTIU,  32'h0, 32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h1, 1'b0, 1'b1});
    v.push_back('{SLTI,   32'h0, 32'h0, 32'h0, 32'h0, 32'hffffffff, 32'h0, 1'b0, 1'b1});
    v.push_back('{JALR,   32'h100, 32'h4, 0, 0, 0, 32'h104, 1'b0, 1'b1});
    v.push_back('{LW,     32'h10, 32'hfffffffc, 0, 0, 0, 32'hc, 1'b0, 1'b1});
    v.push_back('{BEQ,    32'h1, 32'h2, 32'h3, 32'h3, 0, 32'h0, 1'b1, 1'b0});
    v.push_back('{BNE,    32'h1, 32'h2, 32'h3, 32'h3, 0, 32'h0, 1'b0, 1'b0});
    v.push_back('{BLT,    32'h0, 32'h0, 32'hffffffff, 32'h1, 0, 32'h0, 1'b1, 1'b0});
    v.push_back('{BGE,    32'h0, 32'h0, 32'h5, 32'hffffffff, 0, 32'h0, 1'b1, 1'b0});
    v.push_back('{BGEU,   32'h0, 32'h0, 32'h5, 32'hffffffff, 0, 32'h0, 1'b0, 1'b0});
    v.push_back('{BLTU,   32'h0, 32'h0, 32'h5, 32'hffffffff, 0, 32'h0, 1'b1, 1'b0});
    v.push_back('{UNKNOWN, 32'h5, 32'h6, 32'h5, 32'h6, 32'h7, 32'h0, 1'b0, 1'b1});
`ifndef RV32I_M_EXT_EN
    v.push_back('{MUL,    32'h3, 32'h4, 32'h3, 32'h4, 0, 32'h0, 1'b0, 1'b1});
    v.push_back('{DIV,    32'h8, 32'h2, 32'h8, 32'h2, 0, 32'h0, 1'b0, 1'b1});
`endif
    foreach (v[i]) begin
      run_op(v[i].m, v[i].a, v[i].b, v[i].r1, v[i].r2, v[i].im, res, cj, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL lat_%s got %0d want 1", v[i].m.name(), lat); end
      if (v[i].ko) begin
        checks++;
        if (res !== v[i].eo) begin errors++; $display("FAIL out_%s got %h want %h", v[i].m.name(), res, v[i].eo); end
      end
      checks++;
      if (cj !== v[i].ec) begin errors++; $display("FAIL cj_%s got %b want %b", v[i].m.name(), cj, v[i].ec); end
    end
  endtask

`ifdef RV32I_M_EXT_EN
  task automatic test_muldiv;
    vec_t v[$];
    logic [31:0] res; logic cj; int lat;
    v.push_back('{MULH,   32'h80000000, 32'h80000000, 0, 0, 0, 32'h40000000, 1'b0, 1'b1});
    v.push_back('{MULHSU, 32'hffffffff, 32'hffffffff, 0, 0, 0, 32'hffffffff, 1'b0, 1'b1});
    v.push_back('{MULHU,  32'hffffffff, 32'hffffffff, 0, 0, 0, 32'hfffffffe, 1'b0, 1'b1});
    v.push_back('{MUL,    32'h7,        32'hfffffffd, 0, 0, 0, 32'hffffffeb, 1'b0, 1'b1});
    v.push_back('{DIV,    32'h7,        32'h0,        0, 0, 0, 32'hffffffff, 1'b0, 1'b1});
    v.push_back('{REM,    32'h7,        32'h0,        0, 0, 0, 32'h7, 1'b0, 1'b1});
    v.push_back('{DIV,    32'h80000000, 32'hffffffff, 0, 0, 0, 32'h80000000, 1'b0, 1'b1});
    v.push_back('{REM,    32'h80000000, 32'hffffffff, 0, 0, 0, 32'h0, 1'b0, 1'b1});
    v.push_back('{DIV,    32'hfffffff9, 32'h2,        0, 0, 0, 32'hfffffffd, 1'b0, 1'b1});
    v.push_back('{REM,    32'hfffffff9, 32'h2,        0, 0, 0, 32'hffffffff, 1'b0, 1'b1});
    v.push_back('{DIVU,   32'h64,       32'h7,        0, 0, 0, 32'he, 1'b0, 1'b1});
    v.push_back('{REMU,   32'h64,       32'h7,        0, 0, 0, 32'h2, 1'b0, 1'b1});
    v.push_back('{DIV,    32'hfffffff9, 32'h0,        0, 0, 0, 32'hffffffff, 1'b0, 1'b1});
    v.push_back('{REM,    32'hfffffff9, 32'h0,        0, 0, 0, 32'hfffffff9, 1'b0, 1'b1});
    foreach (v[i]) begin
      run_op(v[i].m, v[i].a, v[i].b, v[i].a, v[i].b, 32'h0, res, cj, lat);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL lat_%s got %0d want 33", v[i].m.name(), lat); end
      checks++;
      if (res !== v[i].eo) begin errors++; $display("FAIL out_%s got %h want %h", v[i].m.name(), res, v[i].eo); end
      checks++;
      if (cj !== 1'b0) begin errors++; $display("FAIL cj_%s got %b want 0", v[i].m.name(), cj); end
    end
  endtask
`endif

  task automatic test_back_to_back;
    @(negedge clk);
    mnemonic = ADD; a = 32'h2; b = 32'h3; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    mnemonic = SUB; a = 32'h64; b = 32'h1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        errors++; $display("FAIL hold_flags cyc%0d got ov/ir=%b want 10", i, {out_valid, in_ready});
      end
      checks++;
      if (out !== 32'h5) begin errors++; $display("FAIL hold_out cyc%0d got %h want 5", i, out); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    mnemonic = ADD; a = 32'ha; b = 32'h14; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'h1e) begin
      errors++; $display("FAIL b2b_out got ov=%b out=%h want ov=1 out=1e", out_valid, out);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got ov=%b want 0", out_valid); end
    out_ready = 0;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] res; logic cj; int lat;
    @(negedge clk);
`ifdef RV32I_M_EXT_EN
    mnemonic = DIVU; a = 32'h64; b = 32'h7; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL calc_busy got %b want 1", busy); end
`else
    mnemonic = ADD; a = 32'h2; b = 32'h3; in_valid = 1; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
`endif
    #2 rst_n = 0;
    #1;
    checks++;
    if ({out_valid, busy, cond_jump} !== 3'b000 || out !== 32'h0) begin
      errors++; $display("FAIL async_reset got ov/busy/cj=%b out=%h want 000 out=0", {out_valid, busy, cond_jump}, out);
    end
    @(negedge clk); rst_n = 1;
    run_op(ADD, 32'h1, 32'h2, 32'h0, 32'h0, 32'h0, res, cj, lat);
    checks++;
    if (res !== 32'h3 || lat !== 1) begin
      errors++; $display("FAIL post_reset_add got out=%h lat=%0d want out=3 lat=1", res, lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
`ifdef RV32I_M_EXT_EN
    test_muldiv;
`endif
    test_back_to_back;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_seq_alu.md
RV32_SEQ_ALU -- requirements
Module: rv32_seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (power of two, >= 8).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(XLEN), shift-amount width.
REQ-003 clk  input  1  rising-edge clock; the block SHALL use one clock.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 mnemonic  input  RV32I_INSTRUCTION_MNEMONIC_t  operation select.
REQ-008 a, b, rs1, rs2, imm  input  XLEN each  operands: a/b pre-muxed, rs1/rs2/imm raw. For AUIPC, a carries the PC.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out  output  XLEN  registered result.
REQ-012 cond_jump  output  1  registered branch decision.
REQ-013 busy  output  1  high while in CALC.

Function
REQ-014 SHALL implement FSM IDLE, CALC, DONE; a transfer occurs when in_valid && in_ready.
REQ-015 in_ready SHALL be 1 in IDLE, and in DONE only when out_ready=1 (back-to-back); 0 in CALC.
REQ-016 Single-cycle ops (all base RV32I mnemonics) SHALL go IDLE/DONE->DONE, with out and cond_jump registered at transfer: latency 1 cycle.
REQ-017 ADD/ADDI/loads/stores/JAL/JALR: out=a+b; SUB: a-b; XOR/OR/AND(+I): bitwise a,b; wrap modulo 2^XLEN.
REQ-018 SLL/SRL/SRA(+I) SHALL use b[SHAMT_W-1:0] only; SRA sign-fills.
REQ-019 LUI: out=imm<<12; AUIPC: out=a+(imm<<12).
REQ-020 SLT/SLTU: rs1<rs2 signed/unsigned strict -> 1 else 0; SLTI/SLTIU same vs imm.
REQ-021 cond_jump: BEQ eq, BNE !eq, BLT lt_s, BGE !lt_s, BLTU lt_u, BGEU !lt_u (rs1 vs rs2); 0 for non-branches.
REQ-022 out_valid SHALL be 1 exactly in DONE; out/cond_jump SHALL hold stable until out_ready; DONE->IDLE on out_ready && !in_valid.
REQ-023 Multi-cycle ops (M extension, REQ-031) SHALL go to CALC for exactly XLEN cycles, then DONE: latency XLEN+1 cycles from transfer to out_valid.
REQ-024 MUL/MULH/MULHSU/MULHU: radix-2 shift-add on magnitudes with final sign fix; MUL returns low XLEN bits, MULH* high XLEN bits.
REQ-025 DIV/DIVU/REM/REMU: restoring division, one quotient bit per cycle; signed results truncate toward zero, remainder takes the dividend's sign.
REQ-026 Divide by zero: quotient all-ones, remainder = dividend; still XLEN+1 latency.
REQ-027 Signed overflow (-2^(XLEN-1) / -1): quotient = -2^(XLEN-1), remainder 0.
REQ-028 Operands SHALL be captured at transfer; input changes during CALC SHALL have no effect.
REQ-029 Unknown mnemonic: out=0, cond_jump=0, latency 1.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, out_valid=0, out=0, cond_jump=0, busy=0, iteration counter 0, aborting any CALC; the first post-reset transfer behaves as from cold.

Configuration
REQ-031 Macro RV32I_M_EXT_EN defined: REQ-023..027 active. Undefined: M mnemonics take REQ-029, CALC is unreachable, no multiply/divide logic is instantiated.

Structure
REQ-032 XLEN-independent FSM state typedef (alu_state_t) and the M-mnemonic list SHALL live in be_pkg; mnemonic enum stays in fe_pkg/be_pkg as today.
REQ-033 Iterative multiply/divide datapath SHALL be one sub-module, iter_muldiv (start, op, operands in; done, result out), instantiated only under RV32I_M_EXT_EN.

Verification
REQ-034 ADD a=0xFFFFFFFF b=1 -> out=0, out_valid one cycle after transfer; SRA a=0x80000000 b=0x21 -> 0xC0000000.
REQ-035 BGEU rs1=5 rs2=0xFFFFFFFF -> cond_jump=0; BGE same -> 1; SLTIU rs1=0 imm=0xFFFFFFFF -> 1.
REQ-036 MULH 0x80000000*0x80000000 -> 0x40000000 after 33 cycles; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 DIV 7/0 -> 0xFFFFFFFF, REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; DIV -7/2 -> -3, REM -> -1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> out stable, in_ready=0; then out_ready=1 with in_valid=1 -> next op accepted same cycle.
REQ-039 Drop rst_n mid-CALC (cycle 10 of DIVU) -> out_valid=0, busy=0 immediately; the next ADD completes in 1 cycle with a correct result.
